// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: internal DEPTH x DATA_W RAM with MEM_LAT-cycle access,
// registered write-back outputs and an upstream stall while an access is in flight.
module memory_access_stage #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 2
) (
   input  logic              Clk4,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] B_bypass,
   input  logic [3:0]        Flag,
   input  logic              Mem_en_ex,
   input  logic              Mem_rw_ex,
   input  logic              Mem_mux_sel_ex,
   input  logic [4:0]        Rw_ex,
   output logic [DATA_W-1:0] Wb_data,
   output logic [4:0]        Rw_mem,
   output logic              Reg_wr_mem,
   output logic [3:0]        Flag_mem,
   output logic              Stall_mem
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] addr_q, addr_d, data_q, data_d;
   logic              rw_q, rw_d, sel_q, sel_d;
   logic [4:0]        rd_q, rd_d;
   logic [3:0]        flag_q, flag_d;

   logic [DATA_W-1:0] wb_q, wb_d;
   logic [4:0]        rwm_q, rwm_d;
   logic              regwr_q, regwr_d;
   logic [3:0]        flagm_q, flagm_d;
   logic              stall_q, stall_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] req_addr, req_data, rd_word;
   logic              req_rw, req_sel, complete, mem_we;
   logic [4:0]        req_rd;
   logic [3:0]        req_flag;
   logic [ADDR_W-1:0] ram_idx;

   // In IDLE a single-cycle access completes straight from the inputs; in BUSY from the capture.
   always_comb begin
      req_addr = addr_q;
      req_data = data_q;
      req_rw   = rw_q;
      req_sel  = sel_q;
      req_rd   = rd_q;
      req_flag = flag_q;
      if (state_q == IDLE) begin
         req_addr = ans_ex;
         req_data = B_bypass;
         req_rw   = Mem_rw_ex;
         req_sel  = Mem_mux_sel_ex;
         req_rd   = Rw_ex;
         req_flag = Flag;
      end
   end

   assign ram_idx = req_addr[ADDR_W-1:0];
   assign rd_word = mem_q[ram_idx];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rw_d     = rw_q;
      sel_d    = sel_q;
      rd_d     = rd_q;
      flag_d   = flag_q;
      wb_d     = wb_q;
      rwm_d    = rwm_q;
      regwr_d  = regwr_q;
      flagm_d  = flagm_q;
      stall_d  = stall_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (Mem_en_ex) begin
               addr_d = ans_ex;
               data_d = B_bypass;
               rw_d   = Mem_rw_ex;
               sel_d  = Mem_mux_sel_ex;
               rd_d   = Rw_ex;
               flag_d = Flag;
               if (MEM_LAT == 1) begin
                  complete = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = 4'(MEM_LAT - 1);
                  stall_d = 1'b1;
                  regwr_d = 1'b0;
               end
            end else begin
               wb_d    = ans_ex;
               rwm_d   = Rw_ex;
               flagm_d = Flag;
               regwr_d = (Rw_ex != '0);
               stall_d = 1'b0;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd1) begin
               complete = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
               stall_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               regwr_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (complete) begin
         rwm_d   = req_rd;
         flagm_d = req_flag;
         if (req_rw) begin
            wb_d    = req_addr;
            regwr_d = 1'b0;
         end else begin
            wb_d    = req_sel ? rd_word : req_addr;
            regwr_d = (req_rd != '0);
         end
      end
   end

   assign mem_we = complete & req_rw;

   always_ff @(posedge Clk4) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         sel_q   <= 1'b0;
         rd_q    <= '0;
         flag_q  <= '0;
         wb_q    <= '0;
         rwm_q   <= '0;
         regwr_q <= 1'b0;
         flagm_q <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rw_q    <= rw_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         flag_q  <= flag_d;
         wb_q    <= wb_d;
         rwm_q   <= rwm_d;
         regwr_q <= regwr_d;
         flagm_q <= flagm_d;
         stall_q <= stall_d;
      end
   end

   // RAM is not reset, but a reset edge suppresses any completing write.
   always_ff @(posedge Clk4) begin
      if (Rst_n && mem_we) begin
         mem_q[ram_idx] <= req_data;
      end
   end

   assign Wb_data    = wb_q;
   assign Rw_mem     = rwm_q;
   assign Reg_wr_mem = regwr_q;
   assign Flag_mem   = flagm_q;
   assign Stall_mem  = stall_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench: three instances (MEM_LAT=2, MEM_LAT=4, MEM_LAT=1 with ADDR_W=4),
// expected values queued with a due cycle and compared 1 time unit after that clock edge.
module tb_memory_access_stage;

   logic       clk = 1'b0;
   logic       rst_n [3];
   logic [7:0] ans [3];
   logic [7:0] bb [3];
   logic [3:0] fl [3];
   logic       en [3];
   logic       rw [3];
   logic       sel [3];
   logic [4:0] rwex [3];
   logic [7:0] wb [3];
   logic [4:0] rwm [3];
   logic       regwr [3];
   logic [3:0] flm [3];
   logic       stall [3];

   always #5 clk = ~clk;

   memory_access_stage #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .MEM_LAT(2)) u_lat2 (
      .Clk4(clk), .Rst_n(rst_n[0]), .ans_ex(ans[0]), .B_bypass(bb[0]), .Flag(fl[0]),
      .Mem_en_ex(en[0]), .Mem_rw_ex(rw[0]), .Mem_mux_sel_ex(sel[0]), .Rw_ex(rwex[0]),
      .Wb_data(wb[0]), .Rw_mem(rwm[0]), .Reg_wr_mem(regwr[0]), .Flag_mem(flm[0]),
      .Stall_mem(stall[0]));

   memory_access_stage #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .MEM_LAT(4)) u_lat4 (
      .Clk4(clk), .Rst_n(rst_n[1]), .ans_ex(ans[1]), .B_bypass(bb[1]), .Flag(fl[1]),
      .Mem_en_ex(en[1]), .Mem_rw_ex(rw[1]), .Mem_mux_sel_ex(sel[1]), .Rw_ex(rwex[1]),
      .Wb_data(wb[1]), .Rw_mem(rwm[1]), .Reg_wr_mem(regwr[1]), .Flag_mem(flm[1]),
      .Stall_mem(stall[1]));

   memory_access_stage #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .MEM_LAT(1)) u_lat1 (
      .Clk4(clk), .Rst_n(rst_n[2]), .ans_ex(ans[2]), .B_bypass(bb[2]), .Flag(fl[2]),
      .Mem_en_ex(en[2]), .Mem_rw_ex(rw[2]), .Mem_mux_sel_ex(sel[2]), .Rw_ex(rwex[2]),
      .Wb_data(wb[2]), .Rw_mem(rwm[2]), .Reg_wr_mem(regwr[2]), .Flag_mem(flm[2]),
      .Stall_mem(stall[2]));

   localparam int S_WB = 0, S_RW = 1, S_REGWR = 2, S_FLAG = 3, S_STALL = 4;

   typedef struct {
      int         due;
      int         dut;
      string      tag;
      int         sig;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] get(input int d, input int s);
      case (s)
         S_WB:    return wb[d];
         S_RW:    return {3'b000, rwm[d]};
         S_REGWR: return {7'b0, regwr[d]};
         S_FLAG:  return {4'b0000, flm[d]};
         default: return {7'b0, stall[d]};
      endcase
   endfunction

   function automatic string sname(input int s);
      case (s)
         S_WB:    return "wb";
         S_RW:    return "rw_mem";
         S_REGWR: return "reg_wr";
         S_FLAG:  return "flag";
         default: return "stall";
      endcase
   endfunction

   task automatic push(input int due, input int d, input string tag, input int s,
                       input logic [7:0] v);
      exp_t e;
      e.due = due; e.dut = d; e.tag = tag; e.sig = s; e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_all(input int due, input int d, input string tag, input logic [7:0] w,
                          input logic [4:0] r, input logic g, input logic [3:0] f,
                          input logic st);
      push(due, d, tag, S_WB, w);
      push(due, d, tag, S_RW, {3'b000, r});
      push(due, d, tag, S_REGWR, {7'b0, g});
      push(due, d, tag, S_FLAG, {4'b0000, f});
      push(due, d, tag, S_STALL, {7'b0, st});
   endtask

   task automatic tick();
      logic [7:0] obs;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            obs = get(sb[i].dut, sb[i].sig);
            checks++;
            assert (obs === sb[i].val) else begin
               errors++;
               $error("FAIL %s.%s dut%0d cyc%0d observed %h expected %h", sb[i].tag,
                      sname(sb[i].sig), sb[i].dut, cyc, obs, sb[i].val);
            end
            sb.delete(i);
         end
      end
   endtask

   task automatic drive(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input logic e, input logic w, input logic s,
                        input logic [4:0] r);
      ans[d] = a; bb[d] = b; fl[d] = f; en[d] = e; rw[d] = w; sel[d] = s; rwex[d] = r;
   endtask

   task automatic idle(input int d);
      drive(d, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Stall/bubble expected for lat-1 cycles after acceptance, results lat cycles after drive.
   task automatic mem_op(input int d, input int lat, input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic w, input logic s,
                         input logic [4:0] r, input logic [3:0] f, input logic [7:0] exp_wb);
      int base;
      drive(d, a, b, f, 1'b1, w, s, r);
      base = cyc;
      for (int k = 1; k < lat; k++) begin
         push(base + k, d, tag, S_STALL, 8'h01);
         push(base + k, d, tag, S_REGWR, 8'h00);
      end
      exp_all(base + lat, d, tag, exp_wb, r, (!w && r != 5'd0), f, 1'b0);
      repeat (lat) tick();
   endtask

   task automatic alu_op(input int d, input string tag, input logic [7:0] a,
                         input logic [4:0] r, input logic [3:0] f);
      drive(d, a, 8'hEE, f, 1'b0, 1'b1, 1'b1, r);
      exp_all(cyc + 1, d, tag, a, r, (r != 5'd0), f, 1'b0);
      tick();
   endtask

   initial begin
      int base;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         idle(i);
      end
      // Reset held two cycles with a store request presented on the LAT2 instance.
      drive(0, 8'h55, 8'h99, 4'h9, 1'b1, 1'b1, 1'b1, 5'd3);
      exp_all(1, 0, "reset1", 8'h00, 5'd0, 1'b0, 4'h0, 1'b0);
      exp_all(2, 0, "reset2", 8'h00, 5'd0, 1'b0, 4'h0, 1'b0);
      exp_all(2, 1, "reset_l4", 8'h00, 5'd0, 1'b0, 4'h0, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

      mem_op(0, 2, "first_accept", 8'h55, 8'h99, 1'b0, 1'b0, 5'd3, 4'h1, 8'h55);
      alu_op(0, "alu", 8'h3C, 5'd5, 4'b0010);
      alu_op(0, "alu_r0", 8'h81, 5'd0, 4'hF);
      mem_op(0, 2, "store", 8'h10, 8'hA5, 1'b1, 1'b1, 5'd9, 4'h3, 8'h10);
      mem_op(0, 2, "load", 8'h10, 8'h00, 1'b0, 1'b1, 5'd7, 4'h0, 8'hA5);
      mem_op(0, 2, "load_sel0", 8'h10, 8'h00, 1'b0, 1'b0, 5'd0, 4'h4, 8'h10);
      mem_op(0, 2, "store2", 8'h11, 8'h5A, 1'b1, 1'b0, 5'd2, 4'h6, 8'h11);
      mem_op(0, 2, "raw_load", 8'h11, 8'h00, 1'b0, 1'b1, 5'd31, 4'hA, 8'h5A);
      idle(0);

      mem_op(1, 4, "l4_store", 8'h20, 8'h11, 1'b1, 1'b0, 5'd1, 4'h2, 8'h20);
      mem_op(1, 4, "l4_load", 8'h20, 8'h00, 1'b0, 1'b1, 5'd4, 4'h8, 8'h11);
      alu_op(1, "l4_held_alu", 8'h42, 5'd6, 4'h5);

      // Store 0xFF aborted by reset on the second BUSY cycle.
      drive(1, 8'h20, 8'hFF, 4'h7, 1'b1, 1'b1, 1'b0, 5'd2);
      base = cyc;
      push(base + 1, 1, "abort", S_STALL, 8'h01);
      push(base + 2, 1, "abort", S_STALL, 8'h01);
      tick();
      tick();
      rst_n[1] = 1'b0;
      drive(1, 8'h20, 8'h00, 4'h6, 1'b1, 1'b0, 1'b1, 5'd12);
      exp_all(base + 3, 1, "abort_rst", 8'h00, 5'd0, 1'b0, 4'h0, 1'b0);
      tick();
      tick();
      rst_n[1] = 1'b1;
      mem_op(1, 4, "after_abort", 8'h20, 8'h00, 1'b0, 1'b1, 5'd12, 4'h6, 8'h11);
      idle(1);

      mem_op(2, 1, "wrap_store", 8'h13, 8'h77, 1'b1, 1'b1, 5'd8, 4'h1, 8'h13);
      mem_op(2, 1, "wrap_load", 8'h03, 8'h00, 1'b0, 1'b1, 5'd10, 4'hC, 8'h77);
      alu_op(2, "l1_alu", 8'hC3, 5'd11, 4'h3);
      idle(2);

      repeat (3) tick();
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $error("FAIL %s.%s dut%0d never checked (due cyc%0d) expected %h", sb[0].tag,
                sname(sb[0].sig), sb[0].dut, sb[0].due, sb[0].val);
         void'(sb.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
